// File: rtl/serv_rf_pkg.sv
// serv_rf_pkg: shared state encoding and width helpers for the serial regfile controller.
package serv_rf_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/serv_rf_ctrl_if.sv
// serv_rf_ctrl_if: request side and regfile/ALU side signals of the serial regfile sequencer.
interface serv_rf_ctrl_if #(parameter int W = 32);
    import serv_rf_pkg::*;

    localparam int CNT_W = cnt_w(W);

    logic                  i_req_valid;
    logic                  o_req_ready;
    logic [REG_ADDR_W-1:0] i_rs1_addr;
    logic [REG_ADDR_W-1:0] i_rs2_addr;
    logic [REG_ADDR_W-1:0] i_rd_addr;
    logic                  i_rd_we;
    logic                  i_flush;
    logic                  o_rs_en;
    logic                  o_rd_en;
    logic [REG_ADDR_W-1:0] o_rs1_addr;
    logic [REG_ADDR_W-1:0] o_rs2_addr;
    logic [REG_ADDR_W-1:0] o_rd_addr;
    logic                  o_bit_valid;
    logic [CNT_W-1:0]      o_cnt;
    logic                  o_done;

    modport master (
        output i_req_valid, i_rs1_addr, i_rs2_addr, i_rd_addr, i_rd_we, i_flush,
        input  o_req_ready, o_rs_en, o_rd_en, o_rs1_addr, o_rs2_addr, o_rd_addr,
               o_bit_valid, o_cnt, o_done
    );

    modport slave (
        input  i_req_valid, i_rs1_addr, i_rs2_addr, i_rd_addr, i_rd_we, i_flush,
        output o_req_ready, o_rs_en, o_rd_en, o_rs1_addr, o_rs2_addr, o_rd_addr,
               o_bit_valid, o_cnt, o_done
    );

endinterface

// File: rtl/serv_rf_cnt.sv
// serv_rf_cnt: bit counter with enable, clear and a terminal-count flag at a runtime limit.
module serv_rf_cnt #(parameter int N = 5) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [N-1:0] last,
    output logic [N-1:0] cnt,
    output logic         tc
);

    assign tc = cnt == last;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + 1'b1;

endmodule

// File: rtl/serv_rf_ctrl.sv
// serv_rf_ctrl: sequences one W-cycle bit-serial regfile transfer per request.
// SERV_RF_CTRL_B2B_EN lets a new request be accepted in the last RUN cycle.
module serv_rf_ctrl
    import serv_rf_pkg::*;
#(
    parameter int W      = 32,
    parameter int RD_LAT = 1
) (
    input logic           i_clk,
    input logic           i_rst_n,
    serv_rf_ctrl_if.slave bus
);

    localparam int CNT_W = cnt_w(W);

    state_t           state;
    logic             wr;
    logic [CNT_W-1:0] cnt;
    logic             tc;
    logic             busy;
    logic             last_run;
    logic             ready;
    logic             acc;

    assign busy     = state == PRIME || state == RUN;
    assign last_run = state == RUN && tc;
`ifdef SERV_RF_CTRL_B2B_EN
    assign ready    = state == IDLE || last_run;
`else
    assign ready    = state == IDLE;
`endif
    assign acc      = ready && bus.i_req_valid && !bus.i_flush;

    // One counter serves both phases; the limit switches with the state.
    serv_rf_cnt #(.N(CNT_W)) u_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .en      (busy),
        .clr     (bus.i_flush || tc || !busy),
        .last    (state == PRIME ? CNT_W'(RD_LAT - 1) : CNT_W'(W - 1)),
        .cnt     (cnt),
        .tc      (tc)
    );

    // Read address leads by RD_LAT, so reads stop RD_LAT cycles before RUN ends.
    assign bus.o_req_ready = ready;
    assign bus.o_rs_en     = (state == PRIME || (state == RUN && cnt < CNT_W'(W - RD_LAT))) && !bus.i_flush;
    assign bus.o_rd_en     = state == RUN && wr && !bus.i_flush;
    assign bus.o_bit_valid = state == RUN;
    assign bus.o_cnt       = state == RUN ? cnt : '0;
    assign bus.o_done      = state == DONE || (last_run && acc);

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state          <= IDLE;
            wr             <= 1'b0;
            bus.o_rs1_addr <= '0;
            bus.o_rs2_addr <= '0;
            bus.o_rd_addr  <= '0;
        end else begin
            if (acc) begin
                bus.o_rs1_addr <= bus.i_rs1_addr;
                bus.o_rs2_addr <= bus.i_rs2_addr;
                bus.o_rd_addr  <= bus.i_rd_addr;
                wr             <= bus.i_rd_we && |bus.i_rd_addr;
            end
            state <= acc                   ? PRIME :
                     bus.i_flush && busy   ? IDLE  :
                     state == PRIME && tc  ? RUN   :
                     last_run              ? DONE  :
                     state == DONE         ? IDLE  : state;
        end

endmodule

// File: tb/tb_serv_rf_ctrl.sv
// tb_serv_rf_ctrl: drives RD_LAT=1 and RD_LAT=2 controllers with shared stimulus and
// checks both every cycle against a transfer-timeline model.
module tb_serv_rf_ctrl;

    localparam int W = 32;
`ifdef SERV_RF_CTRL_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       rd_we = 1'b0;
    logic       flush = 1'b0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    int         checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;

    serv_rf_ctrl_if #(.W(W)) ifa ();
    serv_rf_ctrl_if #(.W(W)) ifb ();

    assign ifa.i_req_valid = req_valid;
    assign ifa.i_rs1_addr  = rs1;
    assign ifa.i_rs2_addr  = rs2;
    assign ifa.i_rd_addr   = rd;
    assign ifa.i_rd_we     = rd_we;
    assign ifa.i_flush     = flush;
    assign ifb.i_req_valid = req_valid;
    assign ifb.i_rs1_addr  = rs1;
    assign ifb.i_rs2_addr  = rs2;
    assign ifb.i_rd_addr   = rd;
    assign ifb.i_rd_we     = rd_we;
    assign ifb.i_flush     = flush;

    serv_rf_ctrl #(.W(W), .RD_LAT(1)) u0 (.i_clk(clk), .i_rst_n(rst_n), .bus(ifa));
    serv_rf_ctrl #(.W(W), .RD_LAT(2)) u1 (.i_clk(clk), .i_rst_n(rst_n), .bus(ifb));

    logic       rs_en_v[2], rd_en_v[2], bv_v[2], done_v[2], rdy_v[2];
    logic [4:0] cnt_v[2], a1_v[2], a2_v[2], ad_v[2];

    always_comb begin
        rs_en_v[0] = ifa.o_rs_en;      rs_en_v[1] = ifb.o_rs_en;
        rd_en_v[0] = ifa.o_rd_en;      rd_en_v[1] = ifb.o_rd_en;
        bv_v[0]    = ifa.o_bit_valid;  bv_v[1]    = ifb.o_bit_valid;
        done_v[0]  = ifa.o_done;       done_v[1]  = ifb.o_done;
        rdy_v[0]   = ifa.o_req_ready;  rdy_v[1]   = ifb.o_req_ready;
        cnt_v[0]   = ifa.o_cnt;        cnt_v[1]   = ifb.o_cnt;
        a1_v[0]    = ifa.o_rs1_addr;   a1_v[1]    = ifb.o_rs1_addr;
        a2_v[0]    = ifa.o_rs2_addr;   a2_v[1]    = ifb.o_rs2_addr;
        ad_v[0]    = ifa.o_rd_addr;    ad_v[1]    = ifb.o_rd_addr;
    end

    task automatic chk(input int d, input string n, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL dut%0d cyc %0d %s got %0d exp %0d", d, cyc, n, got, exp);
        end
    endtask

    // Model: p = cycles since acceptance; 1..L prime, L+1..L+W run, L+W+1 done, 0 idle.
    int         p[2] = '{0, 0};
    logic [4:0] m1[2], m2[2], md[2];
    logic       mw[2];
    int         n_rs[2] = '{0, 0}, n_rd[2] = '{0, 0}, n_bv[2] = '{0, 0}, n_done[2] = '{0, 0};
    int         fall[2] = '{0, 0}, gap[2] = '{0, 0};
    logic       pbv[2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            int   l;
            logic run, acc, e_rdy;
            l = d + 1;
            if (!rst_n) begin
                chk(d, "rst_ready", rdy_v[d], 1);
                chk(d, "rst_rs_en", rs_en_v[d], 0);
                chk(d, "rst_rd_en", rd_en_v[d], 0);
                chk(d, "rst_bit_valid", bv_v[d], 0);
                chk(d, "rst_done", done_v[d], 0);
                chk(d, "rst_cnt", cnt_v[d], 0);
                chk(d, "rst_addr", {a1_v[d], a2_v[d], ad_v[d]}, 0);
                p[d] = 0; m1[d] = '0; m2[d] = '0; md[d] = '0; mw[d] = 1'b0;
            end else begin
                run   = p[d] >= l + 1 && p[d] <= l + W;
                e_rdy = p[d] == 0 || (B2B && p[d] == l + W);
                acc   = e_rdy && req_valid && !flush;
                chk(d, "ready", rdy_v[d], e_rdy);
                chk(d, "rs_en", rs_en_v[d], p[d] >= 1 && p[d] <= W && !flush);
                chk(d, "rd_en", rd_en_v[d], run && mw[d] && !flush);
                chk(d, "bit_valid", bv_v[d], run);
                chk(d, "cnt", cnt_v[d], run ? p[d] - l - 1 : 0);
                chk(d, "done", done_v[d], p[d] == l + W + 1 || (B2B && p[d] == l + W && acc));
                chk(d, "rs1_addr", a1_v[d], m1[d]);
                chk(d, "rs2_addr", a2_v[d], m2[d]);
                chk(d, "rd_addr", ad_v[d], md[d]);
                if (acc) begin
                    p[d] = 1; m1[d] = rs1; m2[d] = rs2; md[d] = rd; mw[d] = rd_we && rd != 0;
                end else if (flush && p[d] >= 1 && p[d] <= l + W) p[d] = 0;
                else if (p[d] == l + W + 1) p[d] = 0;
                else if (p[d] != 0) p[d]++;
            end
            n_rs[d]   += int'(rs_en_v[d]);
            n_rd[d]   += int'(rd_en_v[d]);
            n_bv[d]   += int'(bv_v[d]);
            n_done[d] += int'(done_v[d]);
            if (bv_v[d] && !pbv[d]) gap[d] = cyc - fall[d];
            if (!bv_v[d] && pbv[d]) fall[d] = cyc;
            pbv[d] = bv_v[d];
        end
    end

    int b_rs[2], b_rd[2], b_bv[2], b_done[2];

    task automatic snap();
        for (int d = 0; d < 2; d++) begin
            b_rs[d] = n_rs[d]; b_rd[d] = n_rd[d]; b_bv[d] = n_bv[d]; b_done[d] = n_done[d];
        end
    endtask

    task automatic tally(input int d, input int e_rs, input int e_rd, input int e_bv, input int e_done);
        chk(d, "total_rs_en", n_rs[d] - b_rs[d], e_rs);
        chk(d, "total_rd_en", n_rd[d] - b_rd[d], e_rd);
        if (e_bv >= 0) chk(d, "total_bit_valid", n_bv[d] - b_bv[d], e_bv);
        chk(d, "total_done", n_done[d] - b_done[d], e_done);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic we);
        rs1 = a; rs2 = b; rd = c; rd_we = we; req_valid = 1'b1;
        idle(1);
        req_valid = 1'b0;
    endtask

    task automatic wait_cnt0(input int v);
        for (int i = 0; i < 100; i++) begin
            if (ifa.o_bit_valid && int'(ifa.o_cnt) == v) return;
            idle(1);
        end
        chk(0, "wait_cnt_timeout", 0, 1);
    endtask

    initial begin
        idle(2);
        rst_n = 1'b1;
        chk(0, "idle_ready_after_rst", ifa.o_req_ready, 1);

        snap();
        request(5'd3, 5'd5, 5'd7, 1'b1);
        idle(40);
        for (int d = 0; d < 2; d++) tally(d, 32, 32, 32, 1);

        snap();
        request(5'd1, 5'd2, 5'd0, 1'b1);
        idle(40);
        for (int d = 0; d < 2; d++) tally(d, 32, 0, 32, 1);

        snap();
        request(5'd4, 5'd6, 5'd9, 1'b1);
        wait_cnt0(10);
        flush = 1'b1;
        #1;
        chk(0, "flush_rs_en", ifa.o_rs_en, 0);
        chk(0, "flush_rd_en", ifa.o_rd_en, 0);
        idle(1);
        flush = 1'b0;
        chk(0, "flush_cnt", ifa.o_cnt, 0);
        chk(0, "flush_ready", ifa.o_req_ready, 1);
        idle(40);
        tally(0, 11, 10, -1, 0);
        tally(1, 11, 9, -1, 0);

        request(5'd8, 5'd9, 5'd10, 1'b0);
        wait_cnt0(20);
        rst_n = 1'b0;
        #1;
        chk(0, "arst_cnt", ifa.o_cnt, 0);
        chk(0, "arst_bit_valid", ifa.o_bit_valid, 0);
        chk(0, "arst_ready", ifa.o_req_ready, 1);
        chk(0, "arst_rs1", ifa.o_rs1_addr, 0);
        idle(1);
        rst_n = 1'b1;
        snap();
        request(5'd11, 5'd12, 5'd13, 1'b1);
        idle(40);
        for (int d = 0; d < 2; d++) tally(d, 32, 32, 32, 1);

        rs1 = 5'd14; rs2 = 5'd15; rd = 5'd16; rd_we = 1'b1; req_valid = 1'b1;
        idle(80);
        req_valid = 1'b0;
        idle(80);
        chk(0, "b2b_gap", gap[0], B2B ? 1 : 3);
        chk(1, "b2b_gap", gap[1], B2B ? 2 : 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
